// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory: the MEM stage has priority, and the external
// loader/debug port is guaranteed a forced slot after MAX_WAIT consecutive blocked cycles.
module dmem_arbiter #(
    parameter int WORD_LENGTH    = 8,
    parameter int ADDRESS_LENGTH = 8,
    parameter int MAX_WAIT       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [ADDRESS_LENGTH-1:0] cpu_address,
    input  logic [WORD_LENGTH-1:0]    cpu_wdata,
    output logic [WORD_LENGTH-1:0]    cpu_rdata,
    output logic                      cpu_stall,
    input  logic                      ext_valid,
    input  logic                      ext_write,
    input  logic [ADDRESS_LENGTH-1:0] ext_address,
    input  logic [WORD_LENGTH-1:0]    ext_wdata,
    output logic                      ext_ready,
    output logic                      ext_rvalid,
    output logic [WORD_LENGTH-1:0]    ext_rdata,
    output logic [ADDRESS_LENGTH-1:0] mem_address,
    output logic [WORD_LENGTH-1:0]    mem_wdata,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [WORD_LENGTH-1:0]    mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        CPU_OWN,
        FORCE_EXT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cpu_req;
    logic             cpu_grant;
    logic             ext_grant;

    // Grants are combinational so the ext port sees ext_ready in the cycle it is served.
    assign cpu_req   = cpu_read | cpu_write;
    assign ext_grant = ~rst & ext_valid & ((state == FORCE_EXT) | ~cpu_req);
    assign cpu_grant = ~rst & cpu_req & (state == CPU_OWN);

    assign ext_ready = ext_grant;
    assign cpu_stall = ~rst & cpu_req & (state == FORCE_EXT);
    assign cpu_rdata = mem_rdata;

    // A simultaneous CPU read+write is illegal; the write wins and the read strobe is dropped.
    assign mem_address = ext_grant ? ext_address : cpu_address;
    assign mem_wdata   = ext_grant ? ext_wdata : cpu_wdata;
    assign mem_write   = ext_grant ? ext_write : (cpu_grant & cpu_write);
    assign mem_read    = ext_grant ? ~ext_write : (cpu_grant & cpu_read & ~cpu_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CPU_OWN;
            wait_cnt   <= '0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_grant & ~ext_write;
            if (ext_grant & ~ext_write) begin
                ext_rdata <= mem_rdata;
            end
            case (state)
                CPU_OWN: begin
                    if (ext_valid & cpu_req) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= FORCE_EXT;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                FORCE_EXT: begin
                    // The forced slot lasts one cycle so the CPU is never stalled twice in a row.
                    state    <= CPU_OWN;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= CPU_OWN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
